ddf_nda_framer: RTL and testbench

//  Upstream companion of the DDF accumulator actor. Consumes a framed token stream: payload tokens plus
//  end-of-packet delimiter tokens. Forwards each payload on out0 and, per packet, writes the payload count
//  on nda. These become the accumulator's in0 and nda FIFOs. Packets longer than NDA_MAX split into chunks.

---
 rtl/ddf_nda_framer_if.sv | 37 +++
 rtl/ddf_nda_framer.sv | 124 ++++++++++++
 tb/tb_ddf_nda_framer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddf_nda_framer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ddf_nda_framer_if
// Purpose  : Bundle of FIFO-style handshake signals around the DDF nda framer.
//            slave  : framer side (reads in0, writes out0 and nda)
//            master : environment side (upstream/downstream FIFOs)
// Signals  : in0_empty/in0_data/in0_rd   upstream token FIFO (WIDTH+1 bits)
//            out0_full/out0_wr/out0_data  downstream payload FIFO (WIDTH bits)
//            nda_full/nda_wr/nda_data     downstream count FIFO (WIDTH_NDA bits)
// Revision : 1.0  initial release
// ============================================================================
interface ddf_nda_framer_if #(
  parameter int WIDTH     = 32,
  parameter int WIDTH_NDA = 4
) ();
  logic                 in0_empty;
  logic [WIDTH:0]       in0_data;
  logic                 in0_rd;
  logic                 out0_full;
  logic                 out0_wr;
  logic [WIDTH-1:0]     out0_data;
  logic                 nda_full;
  logic                 nda_wr;
  logic [WIDTH_NDA-1:0] nda_data;

  modport slave (
    input  in0_empty, in0_data, out0_full, nda_full,
    output in0_rd, out0_wr, out0_data, nda_wr, nda_data
  );

  modport master (
    output in0_empty, in0_data, out0_full, nda_full,
    input  in0_rd, out0_wr, out0_data, nda_wr, nda_data
  );
endinterface
`default_nettype wire

// File: rtl/ddf_nda_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ddf_nda_framer
// Purpose  : Splits a framed token stream (payloads + end-of-packet
//            delimiters) into a payload stream and a per-packet count stream
//            for the DDF accumulator. Packets longer than NDA_MAX payloads
//            are cut into NDA_MAX-sized chunks, each with its own count.
// Ports    : ck   - clock, rising edge
//            rst  - synchronous reset, active low
//            bus  - slave side of ddf_nda_framer_if (in0 / out0 / nda FIFOs)
// Revision : 1.0  initial release
// ============================================================================
module ddf_nda_framer #(
  parameter int WIDTH     = 32,
  parameter int WIDTH_NDA = 4
) (
  input  logic                ck,
  input  logic                rst,
  ddf_nda_framer_if.slave     bus
);

  localparam int                   NDA_MAX   = (2 ** WIDTH_NDA) - 1;
  localparam logic [WIDTH_NDA-1:0] NDA_MAX_V = NDA_MAX[WIDTH_NDA-1:0];
  localparam logic [WIDTH_NDA-1:0] CNT_ONE   = {{(WIDTH_NDA-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH_NDA-1:0] cnt_q, cnt_d;

  logic                 in0_rd;
  logic                 out0_wr;
  logic [WIDTH-1:0]     out0_data;
  logic                 nda_wr;
  logic [WIDTH_NDA-1:0] nda_data;

  always_ff @(posedge ck) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in0_rd    = 1'b0;
    out0_wr   = 1'b0;
    nda_wr    = 1'b0;
    out0_data = bus.in0_data[WIDTH-1:0];
    nda_data  = cnt_q;

    case (state_q)
      IDLE: begin
        in0_rd  = !bus.in0_empty;
        state_d = bus.in0_empty ? IDLE : PROC;
      end

      // in0_data holds the token fetched by the previous read; a stall
      // simply leaves it there and issues no new read.
      PROC: begin
        if (bus.in0_data[WIDTH]) begin
          if (!bus.nda_full) begin
            nda_wr  = 1'b1;
            cnt_d   = '0;
            in0_rd  = !bus.in0_empty;
            state_d = bus.in0_empty ? IDLE : PROC;
          end
        end else if (!bus.out0_full) begin
          out0_wr = 1'b1;
          if (cnt_q == NDA_MAX_V - CNT_ONE) begin
            // Chunk full: pause reading for one cycle to emit its count.
            cnt_d   = NDA_MAX_V;
            state_d = EMIT;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            in0_rd  = !bus.in0_empty;
            state_d = bus.in0_empty ? IDLE : PROC;
          end
        end
      end

      EMIT: begin
        nda_data = NDA_MAX_V;
        if (!bus.nda_full) begin
          nda_wr  = 1'b1;
          cnt_d   = '0;
          in0_rd  = !bus.in0_empty;
          state_d = bus.in0_empty ? IDLE : PROC;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are forced quiet while reset is asserted, independent of state.
    if (!rst) begin
      in0_rd    = 1'b0;
      out0_wr   = 1'b0;
      nda_wr    = 1'b0;
      out0_data = '0;
      nda_data  = '0;
    end
  end

  assign bus.in0_rd    = in0_rd;
  assign bus.out0_wr   = out0_wr;
  assign bus.out0_data = out0_data;
  assign bus.nda_wr    = nda_wr;
  assign bus.nda_data  = nda_data;

endmodule
`default_nettype wire

// File: tb/tb_ddf_nda_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ddf_nda_framer
// Purpose  : Directed self-checking bench for ddf_nda_framer. A queue models
//            the upstream token FIFO; payload and count writes are logged
//            with their cycle numbers and compared against hand-derived
//            expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_ddf_nda_framer;
  localparam int WIDTH     = 32;
  localparam int WIDTH_NDA = 4;

  logic ck  = 1'b0;
  logic rst = 1'b0;

  ddf_nda_framer_if #(.WIDTH(WIDTH), .WIDTH_NDA(WIDTH_NDA)) bus ();

  ddf_nda_framer #(.WIDTH(WIDTH), .WIDTH_NDA(WIDTH_NDA)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  always #5 ck = ~ck;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  logic [WIDTH:0] fifo[$];
  int out_dat[$];
  int out_cyc[$];
  int nda_dat[$];
  int nda_cyc[$];

  logic                 o_rd, o_wr, o_nwr;
  logic [WIDTH-1:0]     o_dat;
  logic [WIDTH_NDA-1:0] o_ndat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: capture combinational outputs.
  task automatic sample();
    #1;
    o_rd   = bus.in0_rd;
    o_wr   = bus.out0_wr;
    o_nwr  = bus.nda_wr;
    o_dat  = bus.out0_data;
    o_ndat = bus.nda_data;
    if (o_wr) begin
      out_dat.push_back(int'(o_dat));
      out_cyc.push_back(cyc_n);
    end
    if (o_nwr) begin
      nda_dat.push_back(int'(o_ndat));
      nda_cyc.push_back(cyc_n);
    end
  endtask

  // Advance one clock; the FIFO model presents the next token after a read.
  task automatic edge_step();
    @(posedge ck);
    #1;
    if (o_rd && fifo.size() > 0) bus.in0_data = fifo.pop_front();
    bus.in0_empty = (fifo.size() == 0);
    cyc_n++;
    @(negedge ck);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      sample();
      edge_step();
    end
  endtask

  task automatic clr();
    out_dat.delete(); out_cyc.delete();
    nda_dat.delete(); nda_cyc.delete();
  endtask

  task automatic push_pay(input int v);
    fifo.push_back({1'b0, 32'(v)});
    bus.in0_empty = 1'b0;
  endtask

  task automatic push_delim();
    fifo.push_back({1'b1, 32'hFFFF_FFFF});
    bus.in0_empty = 1'b0;
  endtask

  initial begin
    bus.in0_empty = 1'b1;
    bus.in0_data  = {1'b0, 32'hDEAD_BEEF};
    bus.out0_full = 1'b0;
    bus.nda_full  = 1'b0;
    rst = 1'b0;

    // T1: reset with a non-empty upstream FIFO
    push_pay(5); push_pay(7); push_pay(9); push_delim();
    @(negedge ck);
    for (int i = 0; i < 2; i++) begin
      sample();
      chk($sformatf("t1_rd%0d", i), o_rd, 0);
      chk($sformatf("t1_wr%0d", i), o_wr, 0);
      chk($sformatf("t1_nwr%0d", i), o_nwr, 0);
      chk($sformatf("t1_odat%0d", i), o_dat, 0);
      edge_step();
    end
    rst = 1'b1;
    sample();
    chk("t1_first_rd", o_rd, 1);
    edge_step();

    // T2: {5,7,9,DELIM} back-to-back
    run(6);
    chk("t2_nout", out_dat.size(), 3);
    chk("t2_out0", out_dat[0], 5);
    chk("t2_out1", out_dat[1], 7);
    chk("t2_out2", out_dat[2], 9);
    chk("t2_gap01", out_cyc[1] - out_cyc[0], 1);
    chk("t2_gap12", out_cyc[2] - out_cyc[1], 1);
    chk("t2_nnda", nda_dat.size(), 1);
    chk("t2_nda", nda_dat[0], 3);
    chk("t2_nda_lat", nda_cyc[0] - out_cyc[2], 1);
    clr();

    // T3: 18 payloads then DELIM -> chunk of 15, tail of 3
    for (int i = 0; i < 18; i++) push_pay(100 + i);
    push_delim();
    run(25);
    chk("t3_nout", out_dat.size(), 18);
    for (int i = 0; i < 18; i++) chk($sformatf("t3_out%0d", i), out_dat[i], 100 + i);
    chk("t3_nnda", nda_dat.size(), 2);
    chk("t3_nda0", nda_dat[0], 15);
    chk("t3_nda1", nda_dat[1], 3);
    chk("t3_emit_lat", nda_cyc[0] - out_cyc[14], 1);
    chk("t3_bubble", out_cyc[15] - out_cyc[14], 2);
    clr();

    // T4: exactly 15 payloads then DELIM, then a lone DELIM
    for (int i = 0; i < 15; i++) push_pay(40 + i);
    push_delim();
    push_delim();
    run(22);
    chk("t4_nout", out_dat.size(), 15);
    chk("t4_nnda", nda_dat.size(), 3);
    chk("t4_nda0", nda_dat[0], 15);
    chk("t4_nda1", nda_dat[1], 0);
    chk("t4_nda2", nda_dat[2], 0);
    clr();

    // T5: out0_full for 4 cycles mid-packet
    for (int i = 1; i <= 5; i++) push_pay(i);
    push_delim();
    run(3);
    bus.out0_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk($sformatf("t5_stall_wr%0d", i), o_wr, 0);
      chk($sformatf("t5_stall_rd%0d", i), o_rd, 0);
      edge_step();
    end
    bus.out0_full = 1'b0;
    run(6);
    chk("t5_nout", out_dat.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t5_out%0d", i), out_dat[i], i + 1);
    chk("t5_stall_gap", out_cyc[2] - out_cyc[1], 5);
    chk("t5_nnda", nda_dat.size(), 1);
    chk("t5_nda", nda_dat[0], 5);
    clr();

    // T6a: nda_full on a delimiter
    bus.nda_full = 1'b1;
    push_pay(20); push_pay(21); push_delim();
    run(3);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk($sformatf("t6_dstall_nwr%0d", i), o_nwr, 0);
      chk($sformatf("t6_dstall_rd%0d", i), o_rd, 0);
      chk($sformatf("t6_dstall_ndat%0d", i), o_ndat, 2);
      edge_step();
    end
    bus.nda_full = 1'b0;
    sample();
    chk("t6_drel_nwr", o_nwr, 1);
    chk("t6_drel_ndat", o_ndat, 2);
    edge_step();

    // T6b: nda_full while in EMIT
    for (int i = 0; i < 15; i++) push_pay(200 + i);
    push_pay(300); push_pay(301); push_pay(302);
    run(16);
    bus.nda_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk($sformatf("t6_estall_nwr%0d", i), o_nwr, 0);
      chk($sformatf("t6_estall_rd%0d", i), o_rd, 0);
      chk($sformatf("t6_estall_ndat%0d", i), o_ndat, 15);
      edge_step();
    end
    bus.nda_full = 1'b0;
    sample();
    chk("t6_erel_nwr", o_nwr, 1);
    chk("t6_erel_ndat", o_ndat, 15);
    chk("t6_erel_rd", o_rd, 1);
    edge_step();
    clr();
    run(2);
    chk("t6_post_nout", out_dat.size(), 2);
    chk("t6_post_out0", out_dat[0], 300);
    chk("t6_post_out1", out_dat[1], 301);
    clr();

    // T6c: reset mid-packet (count 2 pending), then a lone delimiter
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk($sformatf("t6_rst_rd%0d", i), o_rd, 0);
      chk($sformatf("t6_rst_wr%0d", i), o_wr, 0);
      chk($sformatf("t6_rst_nwr%0d", i), o_nwr, 0);
      chk($sformatf("t6_rst_ndat%0d", i), o_ndat, 0);
      edge_step();
    end
    rst = 1'b1;
    push_delim();
    run(4);
    chk("t6_rst_nout", out_dat.size(), 0);
    chk("t6_rst_nnda", nda_dat.size(), 1);
    chk("t6_rst_nda", nda_dat[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
